// File: rtl/counter_b_pkg.sv
// Shared constants for the counter_b up/down counter.
`timescale 1ns/1ps
package counter_b_pkg;

    localparam int unsigned COUNTER_B_WIDTH = 6;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_b_tc.sv
// Terminal-count detector: flags the value whose next step wraps (or saturates)
// in the current direction.
`timescale 1ns/1ps
module counter_b_tc
    import counter_b_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_B_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             ctrl,
    output logic             ripple_out
);

    always_comb begin
        ripple_out = 1'b0;
        if (ctrl == DIR_UP) begin
            ripple_out = (count == '1);
        end else begin
            ripple_out = (count == '0);
        end
    end

endmodule

// File: rtl/counter_b.sv
// Free-running up/down binary counter with cascadable terminal-count output.
// Build option: define COUNTER_B_SATURATE_EN to saturate instead of wrapping.
`timescale 1ns/1ps
module counter_b
    import counter_b_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_B_WIDTH
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             ctrl,
    output logic [WIDTH-1:0] count,
    output logic             ripple_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_hit;

    counter_b_tc #(
        .WIDTH (WIDTH)
    ) u_tc (
        .count      (count_q),
        .ctrl       (ctrl),
        .ripple_out (tc_hit)
    );

    always_comb begin
        count_d = count_q;
`ifdef COUNTER_B_SATURATE_EN
        // The terminal-count flag doubles as the saturation stop condition.
        if (!tc_hit) begin
            count_d = (ctrl == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
`else
        count_d = (ctrl == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
`endif
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign ripple_out = tc_hit;

endmodule

// File: tb/tb_counter_b.sv
// Directed + random-walk scoreboard bench for counter_b.
`timescale 1ns/1ps
module tb_counter_b;

    localparam int unsigned W   = 6;
    localparam logic [W-1:0] MAXV = 6'd63;

    logic         clk;
    logic         clk_run;
    logic         clear_n;
    logic         ctrl;
    logic [W-1:0] count;
    logic         ripple_out;

    int unsigned  n_checks;
    int unsigned  n_pass;

    logic [W-1:0] model;
    logic [W:0]   exp_q[$];
    string        tag_q[$];

    counter_b #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .ctrl       (ctrl),
        .count      (count),
        .ripple_out (ripple_out)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic exp_rip(input logic [W-1:0] c, input logic d);
        return d ? (c == MAXV) : (c == 6'd0);
    endfunction

    function automatic logic [W-1:0] nxt(input logic [W-1:0] c, input logic d);
`ifdef COUNTER_B_SATURATE_EN
        if (d && c == MAXV) return c;
        if (!d && c == 6'd0) return c;
`endif
        return d ? c + 6'd1 : c - 6'd1;
    endfunction

    task automatic push(input string tag, input logic [W-1:0] c, input logic r);
        exp_q.push_back({r, c});
        tag_q.push_back(tag);
    endtask

    task automatic check();
        logic [W:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard_empty: got no entry, expected one");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        assert (count === e[W-1:0]) n_pass++;
        else $error("FAIL %s count: got %0d expected %0d", t, count, e[W-1:0]);
        n_checks++;
        assert (ripple_out === e[W]) n_pass++;
        else $error("FAIL %s ripple_out: got %b expected %b", t, ripple_out, e[W]);
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            if (clear_n) model = nxt(model, ctrl);
            else         model = '0;
        end
        #1;
    endtask

    task automatic rst_pulse();
        clear_n = 1'b0;
        #1;
        model   = '0;
        clear_n = 1'b1;
    endtask

    initial begin
        clk      = 1'b0;
        clk_run  = 1'b0;
        clear_n  = 1'b0;
        ctrl     = 1'b0;
        model    = '0;
        n_checks = 0;
        n_pass   = 0;

        // Reset with the clock stopped
        #2;
        push("reset_down", 6'd0, 1'b1);
        check();
        ctrl = 1'b1;
        #1;
        push("reset_up", 6'd0, 1'b0);
        check();

        // Up count
        clear_n = 1'b1;
        clk_run = 1'b1;
        push("up30", 6'd30, 1'b0);
        tick(30);
        check();

`ifndef COUNTER_B_SATURATE_EN
        // Up wrap
        rst_pulse();
        push("up63", 6'd63, 1'b1);
        tick(63);
        check();
        push("up_wrap", 6'd0, 1'b0);
        tick(1);
        check();

        // Down wrap
        rst_pulse();
        ctrl = 1'b0;
        #1;
        push("down_at0", 6'd0, 1'b1);
        check();
        push("down_wrap", 6'd63, 1'b0);
        tick(1);
        check();
        push("down_to0", 6'd0, 1'b1);
        tick(63);
        check();

        // Asynchronous reset mid-count
        rst_pulse();
        ctrl = 1'b1;
        push("mid20", 6'd20, 1'b0);
        tick(20);
        check();
        clear_n = 1'b0;
        #3;
        model = '0;
        push("mid_async_rst", 6'd0, 1'b0);
        check();
        clear_n = 1'b1;
        ctrl    = 1'b0;
        #1;
        push("mid_resume_tc", 6'd0, 1'b1);
        check();
        push("mid_resume_wrap", 6'd63, 1'b0);
        tick(1);
        check();
`else
        // Saturation at both ends
        rst_pulse();
        ctrl = 1'b1;
        push("sat_up", 6'd63, 1'b1);
        tick(70);
        check();
        ctrl = 1'b0;
        push("sat_down", 6'd0, 1'b1);
        tick(70);
        check();
`endif

        // ctrl is ignored while reset is held, even with the clock running
        clear_n = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            ctrl = ~ctrl;
            push("hold_rst", 6'd0, ctrl ? 1'b0 : 1'b1);
            tick(1);
            check();
        end
        clear_n = 1'b1;

        // Random direction walk against the reference model
        for (int unsigned i = 0; i < 60; i++) begin
            logic [W-1:0] e;
            ctrl = (i < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            e = nxt(model, ctrl);
            push("walk", e, exp_rip(e, ctrl));
            tick(1);
            check();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
